bsg_dff_negedge_fifo: RTL and testbench

BSG_DFF_NEGEDGE_FIFO -- requirements
Module: bsg_dff_negedge_fifo

---
 rtl/bsg_dff_negedge_fifo_pkg.sv | 20 ++
 rtl/bsg_negedge_circular_ptr.sv | 44 ++++
 rtl/bsg_dff_negedge_fifo.sv | 100 ++++++++++
 tb/tb_bsg_dff_negedge_fifo.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bsg_dff_negedge_fifo_pkg.sv
// Shared constants and helpers for the falling-edge FIFO and its pointer sub-module.
package bsg_dff_negedge_fifo_pkg;

  localparam int default_width_c = 16;
  localparam int default_els_c   = 4;

  // Encodes the per-edge operation as {enqueue, dequeue}
  typedef enum logic [1:0] {
    op_idle_e = 2'b00,
    op_deq_e  = 2'b01,
    op_enq_e  = 2'b10,
    op_both_e = 2'b11
  } fifo_op_e;

  // A single-slot pointer still needs one bit to be a legal vector
  function automatic int ptr_width(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/bsg_negedge_circular_ptr.sv
// Falling-edge wrapping pointer: advances by one on add_i and wraps from slots_p-1 to 0.
module bsg_negedge_circular_ptr
  import bsg_dff_negedge_fifo_pkg::*;
#(
  parameter int slots_p = default_els_c
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          add_i,
  output logic [ptr_width(slots_p)-1:0] ptr_o
);

  localparam int pw_c = ptr_width(slots_p);
  localparam logic [pw_c-1:0] last_c = pw_c'(slots_p - 1);

  logic [pw_c-1:0] ptr_r;
  logic [pw_c-1:0] ptr_n_s;

  // next pointer value with explicit wrap at the last slot
  always_comb begin
    ptr_n_s = ptr_r;
    if (add_i) begin
      if (ptr_r == last_c) begin
        ptr_n_s = '0;
      end else begin
        ptr_n_s = ptr_r + pw_c'(1'b1);
      end
    end else begin
      ptr_n_s = ptr_r;
    end
  end

  // pointer register, synchronous active-low reset on the falling edge
  always_ff @(negedge clk_i) begin
    if (!reset_n_i) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_n_s;
    end
  end

  assign ptr_o = ptr_r;

endmodule

// File: rtl/bsg_dff_negedge_fifo.sv
// Falling-edge circular FIFO with valid/ready in and valid/yumi out.
// Define BSG_DFF_NEGEDGE_FIFO_COUNT_EN to expose the registered occupancy on count_o.
module bsg_dff_negedge_fifo
  import bsg_dff_negedge_fifo_pkg::*;
#(
  parameter int width_p = default_width_c,
  parameter int els_p   = default_els_c
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       yumi_i
`ifdef BSG_DFF_NEGEDGE_FIFO_COUNT_EN
  ,
  output logic [$clog2(els_p+1)-1:0] count_o
`endif
);

  localparam int cw_c = $clog2(els_p + 1);
  localparam int pw_c = ptr_width(els_p);
  localparam logic [cw_c-1:0] full_c = cw_c'(els_p);

  logic [width_p-1:0] mem_r [els_p];
  logic [cw_c-1:0]    count_r;
  logic [cw_c-1:0]    count_n_s;
  logic [pw_c-1:0]    wptr_s;
  logic [pw_c-1:0]    rptr_s;
  logic               enq_s;
  logic               deq_s;
  fifo_op_e           op_s;

  // Handshake flags come from registered occupancy only, never from v_i/yumi_i
  assign ready_o = (count_r != full_c);
  assign v_o     = (count_r != '0);

  // A reset edge performs neither enqueue nor dequeue
  assign enq_s = v_i & ready_o & reset_n_i;
  assign deq_s = yumi_i & v_o & reset_n_i;
  assign op_s  = fifo_op_e'({enq_s, deq_s});

  bsg_negedge_circular_ptr #(.slots_p(els_p)) wptr_inst (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .add_i    (enq_s),
    .ptr_o    (wptr_s)
  );

  bsg_negedge_circular_ptr #(.slots_p(els_p)) rptr_inst (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .add_i    (deq_s),
    .ptr_o    (rptr_s)
  );

  // next occupancy from the combined enqueue/dequeue operation
  always_comb begin
    count_n_s = count_r;
    case (op_s)
      op_enq_e:  count_n_s = count_r + cw_c'(1'b1);
      op_deq_e:  count_n_s = count_r - cw_c'(1'b1);
      op_both_e: count_n_s = count_r;
      op_idle_e: count_n_s = count_r;
      default:   count_n_s = count_r;
    endcase
  end

  // occupancy register
  always_ff @(negedge clk_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else begin
      count_r <= count_n_s;
    end
  end

  // storage array, deliberately left without reset
  always_ff @(negedge clk_i) begin
    if (enq_s) begin
      mem_r[wptr_s] <= data_i;
    end
  end

  assign data_o = mem_r[rptr_s];

`ifdef BSG_DFF_NEGEDGE_FIFO_COUNT_EN
  assign count_o = count_r;
`endif

`ifndef SYNTHESIS
  localparam bit els_pow2_c = ((els_p & (els_p - 32'sd1)) == 32'sd0) && (els_p >= 32'sd2);

  yumi_without_valid: assert property (@(negedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o));
  els_power_of_two:   assert property (@(negedge clk_i) els_pow2_c);
`endif

endmodule

// File: tb/tb_bsg_dff_negedge_fifo.sv
// Directed self-checking bench for bsg_dff_negedge_fifo (width 16, depth 4).
module tb_bsg_dff_negedge_fifo;

  localparam int width_c = 16;
  localparam int els_c   = 4;
  localparam int cw_c    = $clog2(els_c + 1);

  logic               clk;
  logic               reset_n;
  logic               v_in;
  logic [width_c-1:0] data_in;
  logic               ready;
  logic               v_out;
  logic [width_c-1:0] data_out;
  logic               yumi;
`ifdef BSG_DFF_NEGEDGE_FIFO_COUNT_EN
  logic [cw_c-1:0]    count;
`endif

  int tests;
  int failed;

  bsg_dff_negedge_fifo #(.width_p(width_c), .els_p(els_c)) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .v_i      (v_in),
    .data_i   (data_in),
    .ready_o  (ready),
    .v_o      (v_out),
    .data_o   (data_out),
    .yumi_i   (yumi)
`ifdef BSG_DFF_NEGEDGE_FIFO_COUNT_EN
    ,
    .count_o  (count)
`endif
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the rising edge, half a cycle from the active falling edge
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic chk_flags(input string name, input logic exp_ready, input logic exp_v);
    tests++;
    if (ready !== exp_ready) begin
      failed++;
      $display("FAIL %s ready_o got %b expected %b", name, ready, exp_ready);
    end
    tests++;
    if (v_out !== exp_v) begin
      failed++;
      $display("FAIL %s v_o got %b expected %b", name, v_out, exp_v);
    end
  endtask

  task automatic chk_data(input string name, input logic [width_c-1:0] exp_data);
    tests++;
    if (data_out !== exp_data) begin
      failed++;
      $display("FAIL %s data_o got %h expected %h", name, data_out, exp_data);
    end
  endtask

  task automatic chk_count(input string name, input int exp_count);
`ifdef BSG_DFF_NEGEDGE_FIFO_COUNT_EN
    tests++;
    if (count !== cw_c'(exp_count)) begin
      failed++;
      $display("FAIL %s count_o got %0d expected %0d", name, count, exp_count);
    end
`else
    tests++;
    if ((ready !== (exp_count != els_c)) || (v_out !== (exp_count != 0))) begin
      failed++;
      $display("FAIL %s occupancy flags ready=%b v=%b expected count %0d", name, ready, v_out, exp_count);
    end
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0; v_in = 1'b1; data_in = 16'h5555; yumi = 1'b0;
    tick();
    tick();
    chk_flags("reset", 1'b1, 1'b0);
    chk_count("reset", 0);
    reset_n = 1'b1; v_in = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      v_in = 1'b1; data_in = 16'(i);
      tick();
      chk_flags($sformatf("fill_%0d", i), (i < 4) ? 1'b1 : 1'b0, 1'b1);
      chk_data($sformatf("fill_%0d", i), 16'h0001);
    end
    v_in = 1'b0;
    chk_count("fill", 4);
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      chk_data($sformatf("drain_%0d", i), 16'(i + 1));
      yumi = 1'b1;
      tick();
    end
    yumi = 1'b0;
    chk_flags("drain_end", 1'b1, 1'b0);
    chk_count("drain_end", 0);
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 10; n++) begin
      v_in = 1'b1; data_in = 16'hA000 + 16'(n); yumi = 1'b0;
      chk_flags($sformatf("wrap_pre_%0d", n), 1'b1, 1'b0);
      tick();
      v_in = 1'b0;
      chk_flags($sformatf("wrap_enq_%0d", n), 1'b1, 1'b1);
      chk_data($sformatf("wrap_enq_%0d", n), 16'hA000 + 16'(n));
      chk_count($sformatf("wrap_enq_%0d", n), 1);
      yumi = 1'b1;
      tick();
      yumi = 1'b0;
    end
    chk_flags("wrap_end", 1'b1, 1'b0);
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 4; i++) begin
      v_in = 1'b1; data_in = 16'h0011 + 16'(i);
      tick();
    end
    chk_flags("full_pre", 1'b0, 1'b1);
    v_in = 1'b1; yumi = 1'b1; data_in = 16'hBEEF;
    tick();
    v_in = 1'b0; yumi = 1'b0;
    chk_flags("full_simul", 1'b1, 1'b1);
    chk_count("full_simul", 3);
    for (int i = 0; i < 3; i++) begin
      chk_data($sformatf("full_drain_%0d", i), 16'h0012 + 16'(i));
      yumi = 1'b1;
      tick();
    end
    yumi = 1'b0;
    chk_flags("full_drain_end", 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      v_in = 1'b1; data_in = 16'h0021 + 16'(i);
      tick();
    end
    chk_count("midrst_pre", 3);
    reset_n = 1'b0; v_in = 1'b1; data_in = 16'h0099; yumi = 1'b1;
    tick();
    reset_n = 1'b1; yumi = 1'b0; data_in = 16'h1234;
    chk_flags("midrst", 1'b1, 1'b0);
    chk_count("midrst", 0);
    tick();
    v_in = 1'b0;
    chk_flags("midrst_enq", 1'b1, 1'b1);
    chk_data("midrst_enq", 16'h1234);
    chk_count("midrst_enq", 1);
    yumi = 1'b1;
    tick();
    yumi = 1'b0;
    chk_flags("midrst_drain", 1'b1, 1'b0);
  endtask

  initial begin
    tests = 0; failed = 0;
    reset_n = 1'b0; v_in = 1'b0; data_in = '0; yumi = 1'b0;
    @(posedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_full_simul();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
